// File: rtl/render_pattern.sv
// Raster-scans a WIDTH x HEIGHT frame per accepted start, one pixel per oe cycle,
// emitting registered x/y and a colour index from one of four frame-animated patterns.
module render_pattern #(
  parameter int CORDW   = 16,
  parameter int CIDXW   = 4,
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 180,
  parameter int BANDSH  = 4,
  parameter int SPEEDSH = 5,
  parameter int FRAMEW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic [CIDXW-1:0] cidx,
  output logic             drawing,
  output logic             done
);

  localparam int PXW = $clog2(WIDTH);
  localparam int PYW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t            state_q, state_d;
  logic [PXW-1:0]    px_q, px_d;
  logic [PYW-1:0]    py_q, py_d;
  logic [FRAMEW-1:0] frame_q, frame_d;
  logic [1:0]        mode_q, mode_d;
  logic [CIDXW-1:0]  cidx_q, cidx_d;
  logic              drawing_q, drawing_d;
  logic              done_q, done_d;

  logic              load_c;
  logic              last_c;
  logic              chk_c;
  logic [CIDXW-1:0]  f_c;
  logic [CIDXW-1:0]  cidx_new;

  assign last_c = (px_q == PXW'(WIDTH - 1)) && (py_q == PYW'(HEIGHT - 1));

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    frame_d   = frame_q;
    mode_d    = mode_q;
    drawing_d = drawing_q;
    done_d    = 1'b0;
    load_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && oe) begin
          state_d   = DRAW;
          px_d      = '0;
          py_d      = '0;
          frame_d   = frame_q + FRAMEW'(1);
          mode_d    = mode;
          drawing_d = 1'b1;
          load_c    = 1'b1;
        end
      end
      DRAW: begin
        if (oe) begin
          if (last_c) begin
            state_d   = DONE;
            drawing_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            load_c = 1'b1;
            if (px_q == PXW'(WIDTH - 1)) begin
              px_d = '0;
              py_d = py_q + PYW'(1);
            end else begin
              px_d = px_q + PXW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Colour is evaluated on the next pixel/frame/mode so it lands in the same register stage as x/y.
  always_comb begin
    f_c   = CIDXW'(32'(frame_d) >> SPEEDSH);
    chk_c = |(((32'(px_d) ^ 32'(py_d)) >> BANDSH) & 32'd1);
    unique case (mode_d)
      2'd0:    cidx_new = CIDXW'(32'(py_d) >> BANDSH) + f_c;
      2'd1:    cidx_new = CIDXW'(32'(px_d) >> BANDSH) + f_c;
      2'd2:    cidx_new = chk_c ? f_c : ~f_c;
      default: cidx_new = CIDXW'((32'(px_d) + 32'(py_d)) >> BANDSH) + f_c;
    endcase
  end

  always_comb begin
    cidx_d = load_c ? cidx_new : cidx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      px_q      <= '0;
      py_q      <= '0;
      frame_q   <= '0;
      mode_q    <= '0;
      cidx_q    <= '0;
      drawing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      cidx_q    <= cidx_d;
      drawing_q <= drawing_d;
      done_q    <= done_d;
    end
  end

  assign x       = CORDW'(px_q);
  assign y       = CORDW'(py_q);
  assign cidx    = cidx_q;
  assign drawing = drawing_q;
  assign done    = done_q;

endmodule

// File: tb/tb_render_pattern.sv
// Directed bench for render_pattern on a 4x3 frame; instance a uses a 4-bit colour and
// 8-bit frame counter, instance b a 2-bit colour and 2-bit frame counter.
module tb_render_pattern;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        oe = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;

  logic [15:0] xa, ya, xb, yb;
  logic [3:0]  ca;
  logic [1:0]  cb;
  logic        da, dna, db, dnb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  render_pattern #(.CORDW(16), .CIDXW(4), .WIDTH(4), .HEIGHT(3), .BANDSH(0),
                   .SPEEDSH(0), .FRAMEW(8)) dut_a (
    .clk(clk), .rst(rst), .oe(oe), .start(start), .mode(mode),
    .x(xa), .y(ya), .cidx(ca), .drawing(da), .done(dna));

  render_pattern #(.CORDW(16), .CIDXW(2), .WIDTH(4), .HEIGHT(3), .BANDSH(0),
                   .SPEEDSH(0), .FRAMEW(2)) dut_b (
    .clk(clk), .rst(rst), .oe(oe), .start(start), .mode(mode),
    .x(xb), .y(yb), .cidx(cb), .drawing(db), .done(dnb));

  typedef struct {
    logic       oe;
    logic       st;
    logic [1:0] md;
    int         ex, ey, ec, ed, edn;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic o, input logic s, input logic [1:0] m);
    oe = o;
    start = s;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int ex, input int ey, input int ec,
                       input int ed, input int edn);
    chk({nm, "_x"}, int'(xa), ex);
    chk({nm, "_y"}, int'(ya), ey);
    chk({nm, "_cidx"}, int'(ca), ec);
    chk({nm, "_drawing"}, int'(da), ed);
    chk({nm, "_done"}, int'(dna), edn);
  endtask

  initial begin
    int draws;
    int dones;
    int seen;

    // Frame 1, mode 0: raster order, cidx = y + 1; a mid-frame start and a start
    // during the done cycle must both be ignored.
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{oe: 1'b1, st: (i == 0 || i == 5), md: 2'd0,
                 ex: i % 4, ey: i / 4, ec: i / 4 + 1, ed: 1, edn: 0};
    end
    tbl[12] = '{oe: 1'b1, st: 1'b0, md: 2'd0, ex: 3, ey: 2, ec: 3, ed: 0, edn: 1};
    tbl[13] = '{oe: 1'b1, st: 1'b1, md: 2'd1, ex: 3, ey: 2, ec: 3, ed: 0, edn: 0};
    tbl[14] = '{oe: 1'b1, st: 1'b0, md: 2'd0, ex: 3, ey: 2, ec: 3, ed: 0, edn: 0};

    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    chk_a("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    step(1'b0, 1'b1, 2'd0);
    chk("start_without_oe_drawing", int'(da), 0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].oe, tbl[i].st, tbl[i].md);
      chk($sformatf("v%0d_x", i), int'(xa), tbl[i].ex);
      chk($sformatf("v%0d_y", i), int'(ya), tbl[i].ey);
      chk($sformatf("v%0d_cidx", i), int'(ca), tbl[i].ec);
      chk($sformatf("v%0d_drawing", i), int'(da), tbl[i].ed);
      chk($sformatf("v%0d_done", i), int'(dna), tbl[i].edn);
      chk($sformatf("v%0d_b_cidx", i), int'(cb), tbl[i].ec);
    end

    // Frame 2, mode 0, with a three-cycle stall at pixel (2,1).
    step(1'b1, 1'b1, 2'd0);
    chk_a("f2_first", 0, 0, 2, 1, 0);
    chk("f2_first_b_cidx", int'(cb), 2);
    repeat (6) step(1'b1, 1'b0, 2'd0);
    chk_a("f2_at_2_1", 2, 1, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0);
      chk_a($sformatf("stall%0d", i), 2, 1, 3, 1, 0);
    end
    draws = 0;
    dones = 0;
    for (int i = 0; i < 20 && dones == 0; i++) begin
      step(1'b1, 1'b0, 2'd0);
      if (da) draws++;
      if (dna) dones++;
    end
    chk("f2_draws_after_stall", draws, 5);
    chk("f2_done_count", dones, 1);
    chk("f2_done_x", int'(xa), 3);
    chk("f2_done_y", int'(ya), 2);
    step(1'b1, 1'b0, 2'd0);
    chk("f2_done_single", int'(dna), 0);

    // Frame 3, mode 3 (diagonal): a=(x+y+3)&15, b=(x+y+3)&3.
    step(1'b1, 1'b1, 2'd3);
    chk("f3_first_a", int'(ca), 3);
    chk("f3_first_b", int'(cb), 3);
    repeat (11) step(1'b1, 1'b0, 2'd0);
    chk("f3_last_x", int'(xa), 3);
    chk("f3_last_y", int'(ya), 2);
    chk("f3_last_a", int'(ca), 8);
    chk("f3_last_b", int'(cb), 0);
    step(1'b1, 1'b0, 2'd0);
    chk("f3_done", int'(dna), 1);
    step(1'b1, 1'b0, 2'd0);

    // Frame 4 (b wraps to frame 0), mode 2 checker; then reset at pixel (1,1).
    step(1'b1, 1'b1, 2'd2);
    chk("f4_00_a", int'(ca), 11);
    chk("f4_00_b", int'(cb), 3);
    step(1'b1, 1'b0, 2'd0);
    chk("f4_10_a", int'(ca), 4);
    chk("f4_10_b", int'(cb), 0);
    repeat (4) step(1'b1, 1'b0, 2'd0);
    chk("f4_at_x", int'(xa), 1);
    chk("f4_at_y", int'(ya), 1);
    rst = 1'b1;
    step(1'b1, 1'b0, 2'd0);
    rst = 1'b0;
    chk_a("midreset", 0, 0, 0, 0, 0);
    chk("midreset_b_cidx", int'(cb), 0);
    step(1'b0, 1'b0, 2'd0);
    chk("midreset_no_done", int'(dna), 0);

    // After reset the frame counter restarts: mode 3, frame 1.
    step(1'b1, 1'b1, 2'd3);
    chk_a("r1_first", 0, 0, 1, 1, 0);
    repeat (11) step(1'b1, 1'b0, 2'd0);
    chk("r1_last_a", int'(ca), 6);
    chk("r1_last_b", int'(cb), 2);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step(1'b1, 1'b0, 2'd0);
      if (dna) seen = 1;
    end
    chk("r1_done_seen", seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
